// File: rtl/elevator_scheduler.sv
// elevator_scheduler
//   Latches keypad floor requests into a pending bitmap and serves them in
//   SCAN (sweep) order. Times floor-to-floor travel and door dwell, and
//   reports car floor, sweep direction and door state.
//
// Ports
//   CLK            in   clock, rising edge
//   RST            in   asynchronous reset, active low
//   BCD_input[3:0] in   keypad code: 0..NUM_FLOORS-1 floor request, 4'hB cancel
//   BCD_valid      in   one-cycle strobe qualifying BCD_input
//   current_floor  out  floor the car is at or last passed
//   dir_up         out  sweep direction, 1 = up
//   moving         out  car travelling between floors
//   door_open      out  door open
//   pending        out  outstanding request bitmap, bit i = floor i
//   dbg_state      out  FSM state (0 IDLE, 1 MOVE_UP, 2 MOVE_DOWN, 3 DOOR)
//
// Handshake: BCD_input is consumed on every rising edge where BCD_valid is
// high; there is no back-pressure, so every strobe takes effect that edge.
module elevator_scheduler #(
    parameter int NUM_FLOORS  = 10,
    parameter int MOVE_CYCLES = 8,
    parameter int DOOR_CYCLES = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [3:0]            BCD_input,
    input  logic                  BCD_valid,
    output logic [3:0]            current_floor,
    output logic                  dir_up,
    output logic                  moving,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_MOVE_UP   = 2'd1,
        S_MOVE_DOWN = 2'd2,
        S_DOOR      = 2'd3
    } state_t;

    localparam int TMAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] MOVE_LAST = TW'(MOVE_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LAST = TW'(DOOR_CYCLES - 1);
    localparam logic [4:0]    NF5       = 5'(NUM_FLOORS);
    localparam logic [NUM_FLOORS-1:0] ONE_HOT0 = NUM_FLOORS'(1);

    state_t                  state_q, state_d;
    logic [3:0]              floor_q, floor_d;
    logic                    dir_q, dir_d;
    logic [NUM_FLOORS-1:0]   pend_q, pend_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic                    moving_q, moving_d;
    logic                    door_q, door_d;

    logic                    code_is_floor;
    logic                    cancel;
    logic                    door_hold;
    logic [NUM_FLOORS-1:0]   set_mask;
    logic [NUM_FLOORS-1:0]   pend_base;
    logic [3:0]              nxt_floor;
    logic                    more_ahead;

    function automatic logic any_above(input logic [NUM_FLOORS-1:0] p, input logic [3:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (p[i] && (i > int'(f))) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic any_below(input logic [NUM_FLOORS-1:0] p, input logic [3:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (p[i] && (i < int'(f))) r = 1'b1;
        end
        return r;
    endfunction

    assign code_is_floor = BCD_valid && ({1'b0, BCD_input} < NF5);
    assign cancel        = BCD_valid && (BCD_input == 4'hB);
    // A call for the floor whose door is already open just extends the dwell.
    assign door_hold     = (state_q == S_DOOR) && code_is_floor && (BCD_input == floor_q);
    assign set_mask      = (code_is_floor && !door_hold) ? (ONE_HOT0 << BCD_input) : '0;
    // Request bitmap after this edge's strobe; cancel wins over everything.
    assign pend_base     = cancel ? '0 : (pend_q | set_mask);
    assign nxt_floor     = (state_q == S_MOVE_UP) ? (floor_q + 4'd1) : (floor_q - 4'd1);
    assign more_ahead    = (state_q == S_MOVE_UP) ? any_above(pend_base, nxt_floor)
                                                  : any_below(pend_base, nxt_floor);

    always_comb begin
        state_d = state_q;
        floor_d = floor_q;
        dir_d   = dir_q;
        pend_d  = pend_base;
        timer_d = timer_q;
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                // IDLE decides on the registered bitmap, so a fresh request
                // takes effect one edge after it is latched.
                if (!cancel) begin
                    if (pend_q[floor_q]) begin
                        state_d         = S_DOOR;
                        pend_d[floor_q] = 1'b0;
                    end else if (dir_q && any_above(pend_q, floor_q)) begin
                        state_d = S_MOVE_UP;
                    end else if (!dir_q && any_below(pend_q, floor_q)) begin
                        state_d = S_MOVE_DOWN;
                    end else if (any_above(pend_q, floor_q)) begin
                        state_d = S_MOVE_UP;
                        dir_d   = 1'b1;
                    end else if (any_below(pend_q, floor_q)) begin
                        state_d = S_MOVE_DOWN;
                        dir_d   = 1'b0;
                    end
                end
            end
            S_MOVE_UP, S_MOVE_DOWN: begin
                if (timer_q == MOVE_LAST) begin
                    floor_d = nxt_floor;
                    timer_d = '0;
                    if (pend_base[nxt_floor]) begin
                        state_d           = S_DOOR;
                        pend_d[nxt_floor] = 1'b0;
                    end else if (!more_ahead) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_DOOR: begin
                if (door_hold) begin
                    timer_d = '0;
                end else if (timer_q == DOOR_LAST) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
        moving_d = (state_d == S_MOVE_UP) || (state_d == S_MOVE_DOWN);
        door_d   = (state_d == S_DOOR);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            floor_q  <= 4'd0;
            dir_q    <= 1'b1;
            pend_q   <= '0;
            timer_q  <= '0;
            moving_q <= 1'b0;
            door_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            floor_q  <= floor_d;
            dir_q    <= dir_d;
            pend_q   <= pend_d;
            timer_q  <= timer_d;
            moving_q <= moving_d;
            door_q   <= door_d;
        end
    end

    assign current_floor = floor_q;
    assign dir_up        = dir_q;
    assign moving        = moving_q;
    assign door_open     = door_q;
    assign pending       = pend_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
module tb_elevator_scheduler;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_UP   = 2'd1;
    localparam logic [1:0] S_DN   = 2'd2;
    localparam logic [1:0] S_DOOR = 2'd3;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] BCD_input;
    logic       BCD_valid;
    logic [3:0] current_floor;
    logic       dir_up;
    logic       moving;
    logic       door_open;
    logic [9:0] pending;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       valid;
        logic [3:0] code;
        int         wait_n;
        logic [3:0] floor;
        logic       dir;
        logic       mov;
        logic       door;
        logic [9:0] pend;
        logic [1:0] st;
    } vec_t;

    vec_t vecs[$];

    elevator_scheduler #(
        .NUM_FLOORS (10),
        .MOVE_CYCLES(8),
        .DOOR_CYCLES(16)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .BCD_input    (BCD_input),
        .BCD_valid    (BCD_valid),
        .current_floor(current_floor),
        .dir_up       (dir_up),
        .moving       (moving),
        .door_open    (door_open),
        .pending      (pending),
        .dbg_state    (dbg_state)
    );

    // Clock / reset
    always #5 CLK = ~CLK;

    // Scoreboard
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] f, input logic d,
                             input logic m, input logic dr, input logic [9:0] p,
                             input logic [1:0] s);
        chk({tag, " floor"},   32'(current_floor), 32'(f));
        chk({tag, " dir_up"},  32'(dir_up),        32'(d));
        chk({tag, " moving"},  32'(moving),        32'(m));
        chk({tag, " door"},    32'(door_open),     32'(dr));
        chk({tag, " pending"}, 32'(pending),       32'(p));
        chk({tag, " state"},   32'(dbg_state),     32'(s));
    endtask

    // Drivers: inputs change 1 ns after the rising edge, outputs are sampled there too.
    task automatic strobe(input logic v, input logic [3:0] c);
        BCD_valid = v;
        BCD_input = c;
        @(posedge CLK);
        #1;
        BCD_valid = 1'b0;
        BCD_input = 4'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        // Single call 0->3, SCAN sweep 3->6->1, invalid codes, door hold at 4.
        //                valid code  wait flr dir mov door pend     state
        vecs.push_back('{1'b1, 4'h3,  0, 4'd0, 1'b1, 1'b0, 1'b0, 10'h008, S_IDLE});
        vecs.push_back('{1'b0, 4'h0,  0, 4'd0, 1'b1, 1'b1, 1'b0, 10'h008, S_UP});
        vecs.push_back('{1'b0, 4'h0,  6, 4'd0, 1'b1, 1'b1, 1'b0, 10'h008, S_UP});
        vecs.push_back('{1'b0, 4'h0,  0, 4'd1, 1'b1, 1'b1, 1'b0, 10'h008, S_UP});
        vecs.push_back('{1'b0, 4'h0, 15, 4'd3, 1'b1, 1'b0, 1'b1, 10'h000, S_DOOR});
        vecs.push_back('{1'b0, 4'h0, 14, 4'd3, 1'b1, 1'b0, 1'b1, 10'h000, S_DOOR});
        vecs.push_back('{1'b0, 4'h0,  0, 4'd3, 1'b1, 1'b0, 1'b0, 10'h000, S_IDLE});
        vecs.push_back('{1'b1, 4'h6,  1, 4'd3, 1'b1, 1'b1, 1'b0, 10'h040, S_UP});
        vecs.push_back('{1'b1, 4'h1,  0, 4'd3, 1'b1, 1'b1, 1'b0, 10'h042, S_UP});
        vecs.push_back('{1'b1, 4'h6,  0, 4'd3, 1'b1, 1'b1, 1'b0, 10'h042, S_UP});
        vecs.push_back('{1'b0, 4'h0,  5, 4'd4, 1'b1, 1'b1, 1'b0, 10'h042, S_UP});
        vecs.push_back('{1'b0, 4'h0, 15, 4'd6, 1'b1, 1'b0, 1'b1, 10'h002, S_DOOR});
        vecs.push_back('{1'b0, 4'h0, 15, 4'd6, 1'b1, 1'b0, 1'b0, 10'h002, S_IDLE});
        vecs.push_back('{1'b0, 4'h0,  0, 4'd6, 1'b0, 1'b1, 1'b0, 10'h002, S_DN});
        vecs.push_back('{1'b0, 4'h0, 39, 4'd1, 1'b0, 1'b0, 1'b1, 10'h000, S_DOOR});
        vecs.push_back('{1'b0, 4'h0, 15, 4'd1, 1'b0, 1'b0, 1'b0, 10'h000, S_IDLE});
        vecs.push_back('{1'b1, 4'hA,  0, 4'd1, 1'b0, 1'b0, 1'b0, 10'h000, S_IDLE});
        vecs.push_back('{1'b1, 4'hF,  0, 4'd1, 1'b0, 1'b0, 1'b0, 10'h000, S_IDLE});
        vecs.push_back('{1'b1, 4'h4,  0, 4'd1, 1'b0, 1'b0, 1'b0, 10'h010, S_IDLE});
        vecs.push_back('{1'b0, 4'h0,  0, 4'd1, 1'b1, 1'b1, 1'b0, 10'h010, S_UP});
        vecs.push_back('{1'b1, 4'hA,  0, 4'd1, 1'b1, 1'b1, 1'b0, 10'h010, S_UP});
        vecs.push_back('{1'b0, 4'h0, 22, 4'd4, 1'b1, 1'b0, 1'b1, 10'h000, S_DOOR});
        vecs.push_back('{1'b0, 4'h0,  8, 4'd4, 1'b1, 1'b0, 1'b1, 10'h000, S_DOOR});
        vecs.push_back('{1'b1, 4'h4,  0, 4'd4, 1'b1, 1'b0, 1'b1, 10'h000, S_DOOR});
        vecs.push_back('{1'b0, 4'h0, 14, 4'd4, 1'b1, 1'b0, 1'b1, 10'h000, S_DOOR});
        vecs.push_back('{1'b0, 4'h0,  0, 4'd4, 1'b1, 1'b0, 1'b0, 10'h000, S_IDLE});

        RST       = 1'b0;
        BCD_valid = 1'b0;
        BCD_input = 4'h0;
        idle(3);
        check_all("reset", 4'd0, 1'b1, 1'b0, 1'b0, 10'h000, S_IDLE);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            strobe(vecs[i].valid, vecs[i].code);
            idle(vecs[i].wait_n);
            check_all($sformatf("vec%0d", i), vecs[i].floor, vecs[i].dir, vecs[i].mov,
                      vecs[i].door, vecs[i].pend, vecs[i].st);
        end

        // Asynchronous reset in the middle of a move from floor 4 toward 7.
        strobe(1'b1, 4'h7);
        idle(3);
        check_all("premove", 4'd4, 1'b1, 1'b1, 1'b0, 10'h080, S_UP);
        #2;
        RST = 1'b0;
        #1;
        check_all("async_rst", 4'd0, 1'b1, 1'b0, 1'b0, 10'h000, S_IDLE);
        idle(2);
        check_all("rst_held", 4'd0, 1'b1, 1'b0, 1'b0, 10'h000, S_IDLE);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;

        // Cancel between floors 1 and 2 on a trip to 5: stop at 2, no door.
        strobe(1'b1, 4'h5);
        idle(11);
        strobe(1'b1, 4'hB);
        check_all("cancel", 4'd1, 1'b1, 1'b1, 1'b0, 10'h000, S_UP);
        idle(4);
        check_all("cancel_f1", 4'd1, 1'b1, 1'b1, 1'b0, 10'h000, S_UP);
        idle(1);
        check_all("cancel_stop", 4'd2, 1'b1, 1'b0, 1'b0, 10'h000, S_IDLE);
        for (int k = 0; k < 6; k++) begin
            idle(1);
            chk($sformatf("cancel_nodoor%0d", k), 32'(door_open), 32'd0);
        end

        // Arrival race: request floor 3 on the edge the car arrives there.
        strobe(1'b1, 4'h4);
        idle(8);
        check_all("race_pre", 4'd2, 1'b1, 1'b1, 1'b0, 10'h010, S_UP);
        strobe(1'b1, 4'h3);
        check_all("race_arrive", 4'd3, 1'b1, 1'b0, 1'b1, 10'h010, S_DOOR);
        idle(16);
        check_all("race_close", 4'd3, 1'b1, 1'b0, 1'b0, 10'h010, S_IDLE);
        idle(1);
        check_all("race_depart", 4'd3, 1'b1, 1'b1, 1'b0, 10'h010, S_UP);
        idle(7);
        // Cancel on the arrival edge at floor 4: no door, back to IDLE.
        strobe(1'b1, 4'hB);
        check_all("cancel_arrive", 4'd4, 1'b1, 1'b0, 1'b0, 10'h000, S_IDLE);
        idle(2);
        check_all("cancel_after", 4'd4, 1'b1, 1'b0, 1'b0, 10'h000, S_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
